// File: rtl/vga_sig_gen_param.sv
// Parametrised VGA timing generator: pixel divider, raster counters, look-ahead
// frame-buffer addressing with pixel replication and a frame-latched palette.
module vga_sig_gen_param #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_DISP      = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_PW        = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_DISP      = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_PW        = 2,
  parameter int unsigned V_BP        = 29,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned PIX_BITS    = 1,
  parameter int unsigned COLOUR_W    = 8,
  localparam int unsigned N_COL      = 1 << PIX_BITS,
  localparam int unsigned XW         = $clog2(H_DISP >> SCALE_SHIFT),
  localparam int unsigned YW         = $clog2(V_DISP >> SCALE_SHIFT),
  localparam int unsigned ADDR_W     = XW + YW
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_COL*COLOUR_W-1:0] CONFIG_COLOURS,
  input  logic [PIX_BITS-1:0]       VGA_DATA,
  output logic                      PIX_EN,
  output logic [ADDR_W-1:0]         VGA_ADDR,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_BLANK,
  output logic                      FRAME_START,
  output logic [COLOUR_W-1:0]       VGA_COLOUR
);

  localparam int unsigned H_TOT = H_DISP + H_FP + H_PW + H_BP;
  localparam int unsigned V_TOT = V_DISP + V_FP + V_PW + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  // One spare bit so sync end can equal the total without wrapping.
  localparam logic [HW:0]   H_VIS    = (HW+1)'(H_DISP);
  localparam logic [HW:0]   HS_BEG   = (HW+1)'(H_DISP + H_FP);
  localparam logic [HW:0]   HS_END   = (HW+1)'(H_DISP + H_FP + H_PW);
  localparam logic [VW:0]   V_VIS    = (VW+1)'(V_DISP);
  localparam logic [VW:0]   VS_BEG   = (VW+1)'(V_DISP + V_FP);
  localparam logic [VW:0]   VS_END   = (VW+1)'(V_DISP + V_FP + V_PW);

  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nxt;
  logic                      tick;
  logic [HW-1:0]             h;
  logic [VW-1:0]             v;
  logic                      vis;
  logic                      hs_act;
  logic                      vs_act;
  logic [N_COL*COLOUR_W-1:0] pal_q;
  logic [COLOUR_W-1:0]       pal [N_COL];
  logic                      s1_blank;
  logic                      s1_hs;
  logic                      s1_vs;
  logic                      s1_first;

  // Pixel-rate divider; tick marks the last system clock of a pixel period.
  always_comb begin
    tick    = (cnt == CNT_LAST);
    cnt_nxt = tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      PIX_EN <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      cnt    <= cnt_nxt;
      PIX_EN <= (cnt_nxt == CNT_LAST);
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // Palette shadow only changes at the frame wrap so a frame never tears.
  always_ff @(posedge CLK) begin
    if (RESET || (tick && (h == H_LAST) && (v == V_LAST))) begin
      pal_q <= CONFIG_COLOURS;
    end
  end

  for (genvar g = 0; g < N_COL; g++) begin : g_pal
    assign pal[g] = pal_q[(N_COL-1-g)*COLOUR_W +: COLOUR_W];
  end

  always_comb begin
    vis    = ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
    hs_act = ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
    vs_act = ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
  end

  // Stage 1: address issued one clock ahead of the frame-buffer data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      VGA_ADDR <= '0;
      s1_blank <= 1'b1;
      s1_hs    <= ~HS_POL;
      s1_vs    <= ~VS_POL;
      s1_first <= 1'b0;
    end else begin
      VGA_ADDR <= vis ? {YW'(v >> SCALE_SHIFT), XW'(h >> SCALE_SHIFT)} : '0;
      s1_blank <= ~vis;
      s1_hs    <= hs_act ? HS_POL : ~HS_POL;
      s1_vs    <= vs_act ? VS_POL : ~VS_POL;
      s1_first <= (h == '0) && (v == '0) && (cnt == '0);
    end
  end

  // Stage 2: sync/blank aligned with the frame-buffer read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK   <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      VGA_HS      <= s1_hs;
      VGA_VS      <= s1_vs;
      VGA_BLANK   <= s1_blank;
      FRAME_START <= s1_first;
    end
  end

  // VGA_DATA arrives registered by the frame buffer, in step with stage 2.
  assign VGA_COLOUR = VGA_BLANK ? '0 : pal[VGA_DATA];

endmodule

// File: tb/tb_vga_sig_gen_param.sv
// Directed bench: default 640x480 timing instance plus a tiny 4-colour raster.
module tb_vga_sig_gen_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst = 1'b1;
  logic [15:0] d_cfg = 16'hE01C;
  logic        d_data = 1'b0;
  logic        d_pix, d_hs, d_vs, d_blank, d_fs;
  logic [14:0] d_addr;
  logic [7:0]  d_col;

  logic        s_rst = 1'b1;
  logic [31:0] s_cfg = 32'hA1B2C3D4;
  logic [1:0]  s_data = 2'd0;
  logic        s_pix, s_hs, s_vs, s_blank, s_fs;
  logic [4:0]  s_addr;
  logic [7:0]  s_col;

  vga_sig_gen_param u_dflt (
    .CLK(clk), .RESET(d_rst), .CONFIG_COLOURS(d_cfg), .VGA_DATA(d_data),
    .PIX_EN(d_pix), .VGA_ADDR(d_addr), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_BLANK(d_blank), .FRAME_START(d_fs), .VGA_COLOUR(d_col)
  );

  vga_sig_gen_param #(
    .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_PW(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .SCALE_SHIFT(0), .PIX_BITS(2), .COLOUR_W(8)
  ) u_small (
    .CLK(clk), .RESET(s_rst), .CONFIG_COLOURS(s_cfg), .VGA_DATA(s_data),
    .PIX_EN(s_pix), .VGA_ADDR(s_addr), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK(s_blank), .FRAME_START(s_fs), .VGA_COLOUR(s_col)
  );

  // Frame-buffer models with one clock read latency.
  always @(posedge clk) begin
    d_data <= ~d_addr[0];
    s_data <= s_addr[1:0];
  end

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_t(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("d rst hs", d_hs, 1);
    chk("d rst vs", d_vs, 1);
    chk("d rst blank", d_blank, 1);
    chk("d rst col", d_col, 0);
    chk("d rst addr", d_addr, 0);
    chk("d rst fs", d_fs, 0);
    chk("d rst pix", d_pix, 0);
    chk("s rst hs", s_hs, 0);
    chk("s rst vs", s_vs, 1);

    // Small raster, frame = 98 clocks, pixel p on outputs at t = 2 + p.
    s_rst = 1'b0;
    t = 0;
    wait_t(1);
    chk("s t1 addr", s_addr, 0);
    chk("s t1 fs", s_fs, 0);
    chk("s t1 pix", s_pix, 1);
    wait_t(2);
    chk("s t2 fs", s_fs, 1);
    chk("s t2 blank", s_blank, 0);
    chk("s t2 col d0", s_col, 8'hA1);
    chk("s t2 addr", s_addr, 1);
    wait_t(3);
    chk("s t3 fs", s_fs, 0);
    chk("s t3 col d1", s_col, 8'hB2);
    wait_t(4);
    chk("s t4 col d2", s_col, 8'hC3);
    wait_t(5);
    chk("s t5 col d3", s_col, 8'hD4);
    wait_t(10);
    chk("s blank h8", s_blank, 1);
    chk("s col blank", s_col, 0);
    wait_t(11);
    chk("s hs h9", s_hs, 0);
    wait_t(12);
    chk("s hs h10", s_hs, 1);
    wait_t(13);
    chk("s hs h11", s_hs, 1);
    wait_t(14);
    chk("s hs h12", s_hs, 0);
    wait_t(15);
    chk("s blank h13", s_blank, 1);
    wait_t(16);
    chk("s line1 blank", s_blank, 0);
    chk("s line1 fs", s_fs, 0);
    wait_t(30);
    s_cfg = 32'h11223344;
    wait_t(32);
    chk("s old pal d2", s_col, 8'hC3);
    wait_t(45);
    chk("s old pal d1", s_col, 8'hB2);
    wait_t(50);
    chk("s addr h7v3", s_addr, 31);
    wait_t(71);
    chk("s vs v4", s_vs, 1);
    wait_t(72);
    chk("s vs v5 start", s_vs, 0);
    wait_t(85);
    chk("s vs v5 end", s_vs, 0);
    wait_t(86);
    chk("s vs v6", s_vs, 1);
    wait_t(99);
    chk("s fs pre", s_fs, 0);
    wait_t(100);
    chk("s fs frame2", s_fs, 1);
    chk("s new pal d0", s_col, 8'h11);
    wait_t(101);
    chk("s new pal d1", s_col, 8'h22);
    chk("s fs frame2 end", s_fs, 0);
    wait_t(131);
    chk("s new pal d3", s_col, 8'h44);
    // Reset while the raster sits at h=5, v=2 of frame 2.
    s_rst = 1'b1;
    s_cfg = 32'h55667788;
    @(negedge clk);
    chk("s mid rst blank", s_blank, 1);
    chk("s mid rst addr", s_addr, 0);
    chk("s mid rst hs", s_hs, 0);
    chk("s mid rst pix", s_pix, 0);
    chk("s mid rst col", s_col, 0);
    @(negedge clk);
    s_rst = 1'b0;
    t = 0;
    wait_t(1);
    chk("s re t1 fs", s_fs, 0);
    chk("s re t1 addr", s_addr, 0);
    wait_t(2);
    chk("s re t2 fs", s_fs, 1);
    chk("s re pal d0", s_col, 8'h55);
    wait_t(3);
    chk("s re pal d1", s_col, 8'h66);
    wait_t(15);
    chk("s re h13 blank", s_blank, 1);
    wait_t(16);
    chk("s re line1 blank", s_blank, 0);
    chk("s re line1 col", s_col, 8'h55);

    // Default instance, pixel p on outputs at t = 2 + 4p, on ADDR at t = 1 + 4p.
    @(negedge clk);
    d_rst = 1'b0;
    t = 0;
    wait_t(1);
    chk("d t1 addr", d_addr, 0);
    chk("d t1 fs", d_fs, 0);
    chk("d t1 blank", d_blank, 1);
    chk("d t1 pix", d_pix, 0);
    wait_t(2);
    chk("d t2 fs", d_fs, 1);
    chk("d t2 blank", d_blank, 0);
    chk("d t2 col d1", d_col, 8'h1C);
    chk("d t2 hs", d_hs, 1);
    chk("d t2 vs", d_vs, 1);
    wait_t(3);
    chk("d t3 pix", d_pix, 1);
    chk("d t3 fs", d_fs, 0);
    wait_t(4);
    chk("d t4 pix", d_pix, 0);
    wait_t(7);
    chk("d t7 pix", d_pix, 1);
    wait_t(16);
    chk("d addr h3", d_addr, 0);
    wait_t(17);
    chk("d addr h4", d_addr, 1);
    wait_t(18);
    chk("d col d0", d_col, 8'hE0);
    wait_t(2561);
    chk("d h639 blank", d_blank, 0);
    chk("d h639 col", d_col, 8'hE0);
    wait_t(2562);
    chk("d h640 blank", d_blank, 1);
    chk("d h640 col", d_col, 0);
    wait_t(2625);
    chk("d hs h655", d_hs, 1);
    wait_t(2626);
    chk("d hs h656", d_hs, 0);
    wait_t(3009);
    chk("d hs h751", d_hs, 0);
    wait_t(3010);
    chk("d hs h752", d_hs, 1);
    wait_t(3202);
    chk("d line1 blank", d_blank, 0);
    chk("d line1 fs", d_fs, 0);
    chk("d line1 col", d_col, 8'h1C);
    wait_t(12801);
    chk("d addr v4 h0", d_addr, 256);
    chk("d vs v4", d_vs, 1);
    wait_t(15357);
    chk("d addr v4 h639", d_addr, 415);
    wait_t(15361);
    chk("d addr v4 h640", d_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sig_gen_param.md
Name: vga_sig_gen_param

Overview:
- Parametrised successor to the fixed 640x480 VGA signal generator.
- Generates programmable HS/VS timing from one system clock with an internal pixel-rate divider.
- Issues look-ahead frame-buffer read addresses with power-of-two pixel replication.
- Maps multi-bit frame-buffer pixels through a per-frame-latched colour palette to VGA_COLOUR; sits between the dual-port frame buffer and the VGA port.

Parameters:
- CLK_DIV, 4: system clocks per pixel, >=1.
- H_DISP, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_PW, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_DISP, 480: visible lines per frame.
- V_FP, 10: vertical front porch, lines.
- V_PW, 2: vertical sync width, lines.
- V_BP, 29: vertical back porch, lines.
- HS_POL, 0: active level of HS.
- VS_POL, 0: active level of VS.
- SCALE_SHIFT, 2: each frame-buffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- PIX_BITS, 1: bits per frame-buffer pixel; palette has N=2^PIX_BITS entries.
- COLOUR_W, 8: VGA colour width.
- Derived:
  - XW=clog2(H_DISP>>SCALE_SHIFT); YW=clog2(V_DISP>>SCALE_SHIFT); ADDR_W=XW+YW (defaults 8+7=15).
  - H_TOT=H_DISP+H_FP+H_PW+H_BP; V_TOT=V_DISP+V_FP+V_PW+V_BP.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CONFIG_COLOURS  in  N*COLOUR_W  palette; value d maps to bits [(N-1-d)*COLOUR_W +: COLOUR_W], so with PIX_BITS=1, d=1 selects [7:0] and d=0 selects [15:8].
- VGA_DATA  in  PIX_BITS  frame-buffer read data; valid exactly 1 CLK after VGA_ADDR.
- PIX_EN  out  1  one-CLK strobe, once per pixel period.
- VGA_ADDR  out  ADDR_W  {y_fb, x_fb}, x_fb in the low XW bits.
- VGA_HS  out  1  horizontal sync.
- VGA_VS  out  1  vertical sync.
- VGA_BLANK  out  1  high outside the visible area.
- FRAME_START  out  1  one-CLK pulse when pixel (0,0) first reaches the outputs.
- VGA_COLOUR  out  COLOUR_W  pixel colour.

Behaviour:
- Divider:
  - Count 0..CLK_DIV-1.
  - PIX_EN=1 in the CLK where count==CLK_DIV-1.
  - With CLK_DIV=1, PIX_EN is constantly 1 after reset.
- Raster counters:
  - h runs 0..H_TOT-1 and v runs 0..V_TOT-1; both advance only on PIX_EN.
  - h wraps to 0 and increments v; v wraps to 0 after V_TOT-1.
  - Line order is display, front porch, sync, back porch: visible when h<H_DISP and v<V_DISP.
- Sync decode:
  - HS active (=HS_POL) for H_DISP+H_FP <= h < H_DISP+H_FP+H_PW.
  - VS active (=VS_POL) for V_DISP+V_FP <= v < V_DISP+V_FP+V_PW.
- Pipeline, registered every CLK:
  - Stage 1 captures decode of current (h,v): VGA_ADDR = visible ? {v>>SCALE_SHIFT, h>>SCALE_SHIFT} : 0, plus blank, hs and vs.
  - Stage 2 drives VGA_HS, VGA_VS, VGA_BLANK and FRAME_START from stage 1, and VGA_COLOUR = blank ? 0 : palette[VGA_DATA].
  - All outputs for a pixel appear 2 CLK after (h,v) updates and are mutually aligned; each value holds CLK_DIV CLKs.
- Palette:
  - Shadow register loaded from CONFIG_COLOURS during RESET.
  - Also loaded on the CLK where PIX_EN=1 with h=H_TOT-1 and v=V_TOT-1, i.e. the wrap to (0,0).
  - Mid-frame CONFIG_COLOURS changes take effect from the next frame's pixel (0,0); no tearing.
- FRAME_START: 1 for exactly the first CLK in which stage 2 holds (0,0).
- Reset values:
  - Divider, h and v = 0; PIX_EN=0; VGA_ADDR=0.
  - VGA_HS=~HS_POL; VGA_VS=~VS_POL; VGA_BLANK=1; FRAME_START=0; VGA_COLOUR=0.
- Reset release:
  - First CLK after release: stage 1 holds (0,0).
  - Second CLK: outputs show (0,0) with FRAME_START=1.
  - h=0 lasts CLK_DIV CLKs.
- Reset mid-line or mid-frame: all state returns to reset values on that CLK, with no partial-frame completion; the next frame starts from (0,0) as above.
- Width rules:
  - VGA_ADDR fields are truncated to XW/YW bits.
  - h/v counters are clog2(H_TOT)/clog2(V_TOT) bits.
  - No arithmetic overflow is permitted inside the visible area.

Test Plan:
- Defaults, reset held 5 CLK then released -> during reset HS=VS=1, BLANK=1, COLOUR=0, ADDR=0; FRAME_START pulses 2 CLK after release.
- Defaults, free run -> HS low for 384 CLK; line period 3200 CLK; HS falls 2624 CLK after line start; VS low for 6400 CLK; frame period 1,667,200 CLK; PIX_EN period 4.
- Address generation -> h=4..7, v=0 gives ADDR=1; h=639, v=479 gives ADDR=119*256+159=30623; any blank pixel gives ADDR=0.
- CONFIG_COLOURS=16'hE01C, memory model returning 1 then 0 -> COLOUR=8'h1C then 8'hE0; in blanking COLOUR=0 regardless of VGA_DATA.
- Change CONFIG_COLOURS to 16'h03FC at v=100 -> rest of frame still uses 1C/E0; next frame from (0,0) uses FC/03.
- Small set: CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, PIX_BITS=2, SCALE_SHIFT=0, HS_POL=1; assert RESET at h=5, v=2 -> line = 14 CLK, HS high for 2 CLK, 4-entry palette decode correct; restart from (0,0) with FRAME_START 2 CLK after release.
